usb_tx_arbiter: RTL and testbench

- Shares the single FT245R USB transmit byte path between NREQ producers (ADC channels, status sources).
- Grants one pending requester at a time using round-robin order.
- Latches that requester's byte and emits a 4-byte frame to the FT245R FIFO write side: SYNC, CHAN, DATA, CHK.
- Sits between the ADC capture blocks and the FT245R FIFO module, replacing the direct adcstrobe/adcdata hookup.

---
 rtl/usb_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_usb_tx_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - round-robin arbiter framing one requester byte per SYNC/CHAN/DATA/CHK frame
module usb_tx_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   chan_mask,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       frame_count
);

    localparam int LGW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, SYNC, CHAN, DATA, CHK} state_t;

    state_t            state, state_n;
    logic [LGW-1:0]    last_grant, last_grant_n, grant_idx;
    logic              grant_found;
    logic [7:0]        data_r, data_n, chan_r, chan_n, tx_data_n;
    logic [NREQ-1:0]   elig, ack_n;
    logic              tx_valid_n, busy_n, xfer;
    logic [15:0]       frame_count_n;

    // Requester index 'step' places after 'base', wrapping at NREQ.
    function automatic logic [LGW-1:0] rr_index(input logic [LGW-1:0] base, input int step);
        int idx;
        idx = int'(base) + step;
        if (idx >= NREQ)
            idx = idx - NREQ;
        return LGW'(idx);
    endfunction

    assign elig = req & chan_mask & {NREQ{enable}};
    assign xfer = tx_valid & tx_ready;

    // Search starts just past the last winner so a held request waits at most NREQ frames.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && elig[rr_index(last_grant, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(last_grant, k);
            end
        end
    end

    always_comb begin
        state_n       = state;
        last_grant_n  = last_grant;
        data_n        = data_r;
        chan_n        = chan_r;
        ack_n         = '0;
        tx_data_n     = tx_data;
        tx_valid_n    = tx_valid;
        busy_n        = busy;
        frame_count_n = frame_count;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    ack_n[grant_idx] = 1'b1;
                    last_grant_n     = grant_idx;
                    data_n           = req_data[8*grant_idx +: 8];
                    chan_n           = 8'(grant_idx);
                    tx_data_n        = SYNC_BYTE;
                    tx_valid_n       = 1'b1;
                    busy_n           = 1'b1;
                    state_n          = SYNC;
                end
            end
            SYNC: if (xfer) begin
                tx_data_n = chan_r;
                state_n   = CHAN;
            end
            CHAN: if (xfer) begin
                tx_data_n = data_r;
                state_n   = DATA;
            end
            DATA: if (xfer) begin
                tx_data_n = SYNC_BYTE ^ chan_r ^ data_r;
                state_n   = CHK;
            end
            CHK: if (xfer) begin
                tx_data_n     = 8'h00;
                tx_valid_n    = 1'b0;
                busy_n        = 1'b0;
                frame_count_n = frame_count + 16'd1;
                state_n       = IDLE;
            end
            default: begin
                tx_data_n  = 8'h00;
                tx_valid_n = 1'b0;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= LGW'(NREQ - 1);
            data_r      <= 8'h00;
            chan_r      <= 8'h00;
            ack         <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            data_r      <= data_n;
            chan_r      <= chan_n;
            ack         <= ack_n;
            tx_data     <= tx_data_n;
            tx_valid    <= tx_valid_n;
            busy        <= busy_n;
            frame_count <= frame_count_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - directed and randomized bench for usb_tx_arbiter with a frame-level reference model
module tb_usb_tx_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        reset, enable, tx_ready, tx_valid, busy;
    logic [3:0]  chan_mask, req, ack;
    logic [31:0] req_data;
    logic [7:0]  tx_data;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_err = 0;
    logic rearm   = 1'b0;
    logic preload = 1'b0;

    // Reference model: a frame is four bytes, m_pos is the 1-based byte on offer (0 = idle).
    int          m_pos = 0;
    int          m_last = NREQ - 1;
    logic [7:0]  m_frame [4];
    logic [3:0]  m_ack = '0;
    logic [15:0] m_count = '0;

    usb_tx_arbiter #(.NREQ(NREQ), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
        .req(req), .req_data(req_data), .ack(ack), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [3:0] e;
        int g;
        m_ack = '0;
        if (reset) begin
            m_pos   = 0;
            m_count = '0;
            m_last  = NREQ - 1;
        end else begin
            if (preload)
                m_count = 16'hFFFF;
            if (m_pos == 0) begin
                e = req & chan_mask & {4{enable}};
                if (e != 0) begin
                    g = -1;
                    for (int k = 1; k <= NREQ; k++)
                        if (g < 0 && e[(m_last + k) % NREQ])
                            g = (m_last + k) % NREQ;
                    m_ack[g]   = 1'b1;
                    m_last     = g;
                    m_frame[0] = 8'hA5;
                    m_frame[1] = 8'(g);
                    m_frame[2] = req_data[8*g +: 8];
                    m_frame[3] = m_frame[0] ^ m_frame[1] ^ m_frame[2];
                    m_pos      = 1;
                end
            end else if (tx_ready) begin
                if (m_pos == 4) begin
                    m_pos   = 0;
                    m_count = m_count + 16'd1;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, compare every output against the model, then retire acked requests.
    task automatic tick();
        @(negedge clk);
        chk("ack",         32'(ack),         32'(m_ack));
        chk("tx_valid",    32'(tx_valid),    32'(m_pos != 0));
        chk("tx_data",     32'(tx_data),     (m_pos != 0) ? 32'(m_frame[m_pos-1]) : 32'h0);
        chk("busy",        32'(busy),        32'(m_pos != 0));
        chk("frame_count", 32'(frame_count), 32'(m_count));
        for (int i = 0; i < NREQ; i++)
            if (m_ack[i] && !rearm)
                req[i] = 1'b0;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input logic [3:0] exp, input string tag);
        for (int t = 0; t < 20; t++) begin
            tick();
            if (ack !== 4'b0000)
                break;
        end
        chk(tag, 32'(ack), 32'(exp));
    endtask

    initial begin
        logic [3:0] order [5];
        reset = 1'b1; enable = 1'b1; chan_mask = 4'b1111; req = '0;
        req_data = '0; tx_ready = 1'b1;
        tick();
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_frame_count", 32'(frame_count), 32'h0);
        reset = 1'b0;
        tick();

        // Single frame from requester 2
        req_data[23:16] = 8'h3C; req[2] = 1'b1;
        tick();
        chk("t1_ack", 32'(ack), 32'h4);
        chk("t1_sync", 32'(tx_data), 32'hA5);
        tick(); chk("t1_chan", 32'(tx_data), 32'h02);
        tick(); chk("t1_data", 32'(tx_data), 32'h3C);
        tick(); chk("t1_chk",  32'(tx_data), 32'h9B);
        tick();
        chk("t1_busy_done", 32'(busy), 32'h0);
        chk("t1_count", 32'(frame_count), 32'h1);

        // Round-robin with all four held
        reset_dut();
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_data = 32'h4030_2010; rearm = 1'b1; req = 4'b1111;
        for (int f = 0; f < 5; f++)
            wait_ack(order[f], "t2_grant");
        rearm = 1'b0; req = '0;
        drain();
        chk("t2_count", 32'(frame_count), 32'h5);

        // Reset while the frame sits in CHAN
        req_data[7:0] = 8'h77; req[0] = 1'b1;
        tick();
        tick();
        chk("t5_in_chan", 32'(tx_data), 32'h00);
        reset = 1'b1; req = '0;
        tick();
        chk("t5_valid", 32'(tx_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_count", 32'(frame_count), 32'h0);
        reset = 1'b0;
        req_data = 32'h9900_0011; req = 4'b1001;
        tick();
        chk("t5_regrant", 32'(ack), 32'h1);
        req = '0;
        drain();

        // Back-pressure in DATA
        req_data[15:8] = 8'hFF; req[1] = 1'b1;
        tick(); chk("t3_sync", 32'(tx_data), 32'hA5);
        tick(); chk("t3_chan", 32'(tx_data), 32'h01);
        tick(); chk("t3_data", 32'(tx_data), 32'hFF);
        tx_ready = 1'b0;
        repeat (7) begin
            tick();
            chk("t3_hold_data", 32'(tx_data), 32'hFF);
            chk("t3_hold_valid", 32'(tx_valid), 32'h1);
        end
        tx_ready = 1'b1;
        tick(); chk("t3_chk", 32'(tx_data), 32'h5B);
        tick(); chk("t3_idle", 32'(tx_valid), 32'h0);

        // Masking and global enable
        chan_mask = 4'b1101; req[1] = 1'b1; req_data[15:8] = 8'h42;
        repeat (3) begin
            tick();
            chk("t4_mask_ack", 32'(ack), 32'h0);
            chk("t4_mask_valid", 32'(tx_valid), 32'h0);
        end
        chan_mask = 4'b1111; enable = 1'b0;
        repeat (3) begin
            tick();
            chk("t4_en_ack", 32'(ack), 32'h0);
        end
        enable = 1'b1;
        tick();
        chk("t4_grant", 32'(ack), 32'h2);
        drain();

        // Counter wrap
        preload = 1'b1;
        force dut.frame_count = 16'hFFFF;
        #1 release dut.frame_count;
        tick();
        preload = 1'b0;
        chk("t6_preload", 32'(frame_count), 32'hFFFF);
        req_data[23:16] = 8'h5A; req[2] = 1'b1;
        repeat (5) tick();
        chk("t6_wrap", 32'(frame_count), 32'h0);
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            tx_ready = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 15) != 0);
            reset    = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0)
                chan_mask = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
